// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the direct-mapped refill cache.
package cache_pkg;

  typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_e;

  function automatic int off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int tag_w(input int addr_w, input int index_w, input int words);
    return addr_w - index_w - $clog2(words);
  endfunction

  function automatic int lines(input int index_w);
    return 1 << index_w;
  endfunction

  // Extract 'width' bits starting at 'lsb' from a zero-extended word address.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    return (addr >> lsb) & ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_data_ram.sv
// Simple dual-port word array: synchronous refill write, combinational lookup read.
module cache_data_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_dm_refill.sv
// Direct-mapped read-only cache; misses refill a whole aligned line, then answer.
// Hit answers one edge after accept, miss WORDS_PER_LINE+MEM_LAT+1 edges after.
module cache_dm_refill import cache_pkg::*; #(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 32,
  parameter int INDEX_W        = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LAT        = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_hit,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF_W = off_w(WORDS_PER_LINE);
  localparam int TAG_W = tag_w(ADDR_W, INDEX_W, WORDS_PER_LINE);
  localparam int LINES = lines(INDEX_W);

  if (TAG_W < 1) begin : g_bad_tag
    $error("cache_dm_refill: ADDR_W leaves no tag bits");
  end
  if (WORDS_PER_LINE < 2 || (1 << OFF_W) != WORDS_PER_LINE) begin : g_bad_words
    $error("cache_dm_refill: WORDS_PER_LINE must be a power of two >= 2");
  end

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];
  logic [OFF_W:0]      iss_cnt_q;
  logic [OFF_W-1:0]    cap_cnt_q;
  logic [MEM_LAT-1:0]  cap_pipe_q;
  logic                flush_pend_q;
  logic                resp_valid_q, resp_hit_q, mem_en_q;
  logic [DATA_W-1:0]   resp_data_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [31:0]         addr_ext;
  logic [OFF_W-1:0]    off;
  logic [INDEX_W-1:0]  idx;
  logic [TAG_W-1:0]    tag;
  logic                hit, cap_vld, cap_last;
  logic [DATA_W-1:0]   ram_rdata;

  assign addr_ext = 32'(addr_q);
  assign off      = OFF_W'(addr_field(addr_ext, 0, OFF_W));
  assign idx      = INDEX_W'(addr_field(addr_ext, OFF_W, INDEX_W));
  assign tag      = TAG_W'(addr_field(addr_ext, OFF_W + INDEX_W, TAG_W));

  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign cap_vld  = (state_q == REFILL) && cap_pipe_q[MEM_LAT-1];
  assign cap_last = cap_vld && (cap_cnt_q == OFF_W'(WORDS_PER_LINE - 1));

  assign req_ready  = (state_q == IDLE) && !flush && !flush_pend_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_hit   = resp_hit_q;
  assign mem_en     = mem_en_q;
  assign mem_addr   = mem_addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  cache_data_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (LINES * WORDS_PER_LINE)
  ) u_data_ram (
    .clk   (clk),
    .we    (cap_vld),
    .waddr ({idx, cap_cnt_q}),
    .wdata (mem_rdata),
    .raddr ({idx, off}),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (cap_last) tag_q[idx] <= tag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      valid_q      <= '0;
      iss_cnt_q    <= '0;
      cap_cnt_q    <= '0;
      cap_pipe_q   <= '0;
      flush_pend_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_data_q  <= '0;
      mem_en_q     <= 1'b0;
      mem_addr_q   <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      // Delay line marks the cycle each issued word arrives on mem_rdata.
      cap_pipe_q   <= (cap_pipe_q << 1) | MEM_LAT'(mem_en_q);
      case (state_q)
        IDLE: begin
          if (flush || flush_pend_q) begin
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
          end else if (req_valid) begin
            addr_q  <= req_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (flush) flush_pend_q <= 1'b1;
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_data_q  <= ram_rdata;
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
            state_q      <= IDLE;
          end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
            mem_en_q   <= 1'b1;
            mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
            iss_cnt_q  <= (OFF_W+1)'(1);
            cap_cnt_q  <= '0;
            state_q    <= REFILL;
          end
        end
        REFILL: begin
          if (flush) flush_pend_q <= 1'b1;
          if (mem_en_q) begin
            if (iss_cnt_q == (OFF_W+1)'(WORDS_PER_LINE)) begin
              mem_en_q <= 1'b0;
            end else begin
              mem_addr_q <= {tag, idx, iss_cnt_q[OFF_W-1:0]};
              iss_cnt_q  <= iss_cnt_q + 1'b1;
            end
          end
          if (cap_vld) cap_cnt_q <= cap_cnt_q + 1'b1;
          if (cap_last) begin
            valid_q[idx] <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b0;
            // The last word is still on the bus, not yet in the array.
            resp_data_q  <= (off == cap_cnt_q) ? mem_rdata : ram_rdata;
            state_q      <= IDLE;
          end
        end
        RESPOND: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
